// File: rtl/fetch_ref_luma_load.sv
// fetch_ref_luma_load: fetches the 80-row luma reference window for one LCU.
// Each row is requested from external memory and collected as six 128-bit beats.
// The assembled 96-pixel row is then written to the reference buffer.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif
`ifndef PIC_Y_WIDTH
`define PIC_Y_WIDTH 8
`endif

module fetch_ref_luma_load #(
  parameter int ROW_NUM  = 80,
  parameter int BEAT_NUM = 6
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          sysif_start_i,
  input  logic [`PIC_X_WIDTH-1:0]       sysif_cur_x_i,
  input  logic [`PIC_Y_WIDTH-1:0]       sysif_cur_y_i,
  input  logic [`PIC_Y_WIDTH-1:0]       sysif_total_y_i,
  output logic                          ext_rd_req_o,
  output logic [`PIC_X_WIDTH+7-1:0]     ext_rd_x_o,
  output logic [`PIC_Y_WIDTH+6-1:0]     ext_rd_y_o,
  input  logic                          ext_rd_ack_i,
  input  logic                          ext_rd_valid_i,
  input  logic [127:0]                  ext_rd_data_i,
  output logic                          ext_load_valid_o,
  output logic [6:0]                    ext_load_addr_o,
  output logic [96*`PIXEL_WIDTH-1:0]    ext_load_data_o,
  output logic                          ext_load_done_o,
  output logic                          busy_o
);

  localparam int ROW_W = 96 * `PIXEL_WIDTH;
  localparam int XW    = `PIC_X_WIDTH + 7;
  localparam int YW    = `PIC_Y_WIDTH + 6;
  localparam int SW    = YW + 2;
  localparam int BW    = $clog2(BEAT_NUM + 1);

  typedef enum logic [2:0] {IDLE, REQ, DATA, WR, DONE} state_t;

  state_t                   state, state_nxt;
  logic [`PIC_X_WIDTH-1:0]  cur_x;
  logic [`PIC_Y_WIDTH-1:0]  cur_y;
  logic [`PIC_Y_WIDTH-1:0]  total_y;
  logic [6:0]               row_cnt;
  logic [BW-1:0]            beat_cnt;
  logic [ROW_W-1:0]         row_reg;

  logic                     last_beat;
  logic                     last_row;
  logic [XW-1:0]            x_calc;
  logic signed [SW-1:0]     y_raw;
  logic signed [SW-1:0]     y_max;
  logic [YW-1:0]            y_clamped;

  assign last_beat = ext_rd_valid_i && (beat_cnt == BW'(BEAT_NUM - 1));
  assign last_row  = (row_cnt == 7'(ROW_NUM - 1));

  // Window starts 16 pixels left of the LCU; the subtraction wraps to two's complement.
  assign x_calc = {1'b0, cur_x, 6'b0} - XW'(16);

  // Window starts 8 rows above the LCU and the last legal row ends the bottom LCU row.
  assign y_raw = $signed({2'b00, cur_y, 6'b0}) - $signed(SW'(8))
               + $signed({{(SW-7){1'b0}}, row_cnt});
  assign y_max = $signed({2'b00, total_y, 6'b111111});

  // Clamp the requested row into the picture vertically.
  always_comb begin
    y_clamped = y_raw[YW-1:0];
    if (y_raw < 0) begin
      y_clamped = '0;
    end else if (y_raw > y_max) begin
      y_clamped = y_max[YW-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a start pulse restarts the window from any state.
  always_comb begin
    state_nxt = state;
    if (sysif_start_i) begin
      state_nxt = REQ;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        REQ:     if (ext_rd_ack_i) state_nxt = DATA;
        DATA:    if (last_beat) state_nxt = WR;
        WR:      state_nxt = last_row ? DONE : REQ;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Coordinate latches, row/beat counters and the row assembly shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_x    <= '0;
      cur_y    <= '0;
      total_y  <= '0;
      row_cnt  <= '0;
      beat_cnt <= '0;
      row_reg  <= '0;
    end else if (sysif_start_i) begin
      cur_x    <= sysif_cur_x_i;
      cur_y    <= sysif_cur_y_i;
      total_y  <= sysif_total_y_i;
      row_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        REQ: begin
          if (ext_rd_ack_i) beat_cnt <= '0;
        end
        DATA: begin
          if (ext_rd_valid_i) begin
            row_reg  <= {row_reg[ROW_W-129:0], ext_rd_data_i};
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        WR: begin
          if (!last_row) row_cnt <= row_cnt + 7'd1;
        end
        default: ;
      endcase
    end
  end

  // Output decode; everything not owned by the current state is driven to zero.
  always_comb begin
    ext_rd_req_o     = 1'b0;
    ext_rd_x_o       = '0;
    ext_rd_y_o       = '0;
    ext_load_valid_o = 1'b0;
    ext_load_addr_o  = '0;
    ext_load_data_o  = '0;
    ext_load_done_o  = 1'b0;
    busy_o           = (state != IDLE);
    case (state)
      REQ: begin
        ext_rd_req_o = 1'b1;
        ext_rd_x_o   = x_calc;
        ext_rd_y_o   = y_clamped;
      end
      WR: begin
        ext_load_valid_o = 1'b1;
        ext_load_addr_o  = row_cnt;
        ext_load_data_o  = row_reg;
      end
      DONE: ext_load_done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_ref_luma_load.sv
// tb_fetch_ref_luma_load: table-driven bench with a memory responder and a row scoreboard.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif
`ifndef PIC_Y_WIDTH
`define PIC_Y_WIDTH 8
`endif

module tb_fetch_ref_luma_load;

  localparam int ROW_NUM  = 80;
  localparam int BEAT_NUM = 6;
  localparam int ROW_W    = 96 * `PIXEL_WIDTH;
  localparam int PXW      = `PIC_X_WIDTH;
  localparam int PYW      = `PIC_Y_WIDTH;
  localparam int XW       = PXW + 7;
  localparam int YW       = PYW + 6;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             sysif_start_i = 1'b0;
  logic [PXW-1:0]   sysif_cur_x_i = '0;
  logic [PYW-1:0]   sysif_cur_y_i = '0;
  logic [PYW-1:0]   sysif_total_y_i = '0;
  logic             ext_rd_req_o;
  logic [XW-1:0]    ext_rd_x_o;
  logic [YW-1:0]    ext_rd_y_o;
  logic             ext_rd_ack_i = 1'b0;
  logic             ext_rd_valid_i = 1'b0;
  logic [127:0]     ext_rd_data_i = '0;
  logic             ext_load_valid_o;
  logic [6:0]       ext_load_addr_o;
  logic [ROW_W-1:0] ext_load_data_o;
  logic             ext_load_done_o;
  logic             busy_o;

  always #5 clk = ~clk;

  fetch_ref_luma_load #(.ROW_NUM(ROW_NUM), .BEAT_NUM(BEAT_NUM)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .sysif_start_i    (sysif_start_i),
    .sysif_cur_x_i    (sysif_cur_x_i),
    .sysif_cur_y_i    (sysif_cur_y_i),
    .sysif_total_y_i  (sysif_total_y_i),
    .ext_rd_req_o     (ext_rd_req_o),
    .ext_rd_x_o       (ext_rd_x_o),
    .ext_rd_y_o       (ext_rd_y_o),
    .ext_rd_ack_i     (ext_rd_ack_i),
    .ext_rd_valid_i   (ext_rd_valid_i),
    .ext_rd_data_i    (ext_rd_data_i),
    .ext_load_valid_o (ext_load_valid_o),
    .ext_load_addr_o  (ext_load_addr_o),
    .ext_load_data_o  (ext_load_data_o),
    .ext_load_done_o  (ext_load_done_o),
    .busy_o           (busy_o)
  );

  typedef struct {
    logic [6:0]       addr;
    logic [ROW_W-1:0] data;
  } wr_exp_t;

  typedef struct {
    logic [PXW-1:0] cur_x;
    logic [PYW-1:0] cur_y;
    logic [PYW-1:0] total_y;
    int             ack_delay;
    int             gap;
    bit             noise;
    logic [XW-1:0]  exp_x;
    logic [YW-1:0]  exp_y_first;
    logic [YW-1:0]  exp_y_last;
  } vec_t;

  wr_exp_t sb_q[$];
  vec_t    vecs[4];
  int      n_cmp = 0;
  int      n_err = 0;
  int      done_cnt = 0;

  function automatic void check_output(string name, logic [ROW_W-1:0] act, logic [ROW_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t make_vec(int cx, int cy, int ty, int dly, int gap, bit noise,
                                    int ex, int ey0, int ey79);
    vec_t v;
    v.cur_x       = PXW'(cx);
    v.cur_y       = PYW'(cy);
    v.total_y     = PYW'(ty);
    v.ack_delay   = dly;
    v.gap         = gap;
    v.noise       = noise;
    v.exp_x       = XW'(ex);
    v.exp_y_first = YW'(ey0);
    v.exp_y_last  = YW'(ey79);
    return v;
  endfunction

  function automatic logic [YW-1:0] model_y(int cy, int ty, int row);
    int y;
    int ymax;
    y    = cy * 64 - 8 + row;
    ymax = (ty + 1) * 64 - 1;
    if (y < 0) y = 0;
    else if (y > ymax) y = ymax;
    return YW'(y);
  endfunction

  // Write-side monitor: pops the scoreboard on each row strobe and watches strobe exclusivity.
  always @(negedge clk) begin
    if (rstn) begin
      check_output("strobe_exclusive",
                   ((int'(ext_rd_req_o) + int'(ext_load_valid_o) + int'(ext_load_done_o)) > 1) ? 1 : 0, 0);
      if (ext_load_valid_o) begin
        if (sb_q.size() == 0) begin
          check_output("unexpected_wr_addr", ext_load_addr_o, 7'h7f);
        end else begin
          wr_exp_t e;
          e = sb_q.pop_front();
          check_output("wr_addr", ext_load_addr_o, e.addr);
          check_output("wr_data", ext_load_data_o, e.data);
        end
      end
      if (ext_load_done_o) done_cnt++;
    end
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (ext_rd_req_o) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check_output("req_timeout", 0, 1);
  endtask

  task automatic apply_stimulus(input vec_t v);
    sysif_cur_x_i   = v.cur_x;
    sysif_cur_y_i   = v.cur_y;
    sysif_total_y_i = v.total_y;
    sysif_start_i   = 1'b1;
    @(negedge clk);
    sysif_start_i   = 1'b0;
    sysif_cur_x_i   = ~v.cur_x;
    sysif_cur_y_i   = ~v.cur_y;
    sysif_total_y_i = ~v.total_y;
  endtask

  // One row handshake; stop_after >= 0 abandons the row after that many beats.
  task automatic run_row(input int row, input vec_t v, input int stop_after);
    bit               ok;
    logic [127:0]     beats[BEAT_NUM];
    logic [ROW_W-1:0] exp_row;
    logic [YW-1:0]    exp_y;
    wr_exp_t          e;
    wait_req(ok);
    if (!ok) return;
    exp_y = model_y(int'(v.cur_y), int'(v.total_y), row);
    check_output("rd_x", ext_rd_x_o, v.exp_x);
    check_output("rd_y", ext_rd_y_o, exp_y);
    if (row == 0) check_output("rd_y_first", ext_rd_y_o, v.exp_y_first);
    if (row == ROW_NUM - 1) check_output("rd_y_last", ext_rd_y_o, v.exp_y_last);
    for (int d = 0; d < v.ack_delay; d++) begin
      if (v.noise) begin
        ext_rd_valid_i = 1'b1;
        ext_rd_data_i  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      ext_rd_valid_i = 1'b0;
      check_output("req_hold", ext_rd_req_o, 1);
      check_output("rd_x_hold", ext_rd_x_o, v.exp_x);
      check_output("rd_y_hold", ext_rd_y_o, exp_y);
    end
    ext_rd_ack_i = 1'b1;
    @(negedge clk);
    ext_rd_ack_i = 1'b0;
    check_output("req_drop", ext_rd_req_o, 0);
    for (int b = 0; b < BEAT_NUM; b++) begin
      if (b == stop_after) return;
      beats[b]       = {$urandom, $urandom, $urandom, $urandom};
      ext_rd_valid_i = 1'b1;
      ext_rd_data_i  = beats[b];
      if (b == BEAT_NUM - 1) begin
        exp_row = '0;
        for (int k = 0; k < BEAT_NUM; k++) exp_row[ROW_W-1-128*k -: 128] = beats[k];
        e.addr = 7'(row);
        e.data = exp_row;
        sb_q.push_back(e);
      end
      @(negedge clk);
      ext_rd_valid_i = 1'b0;
      if (b < BEAT_NUM - 1) begin
        for (int g = 0; g < v.gap; g++) begin
          if (v.noise) ext_rd_ack_i = 1'b1;
          @(negedge clk);
          ext_rd_ack_i = 1'b0;
        end
      end
    end
    check_output("wr_latency", ext_load_valid_o, 1);
  endtask

  task automatic finish_load(input vec_t v, input int d0);
    for (int r = 0; r < ROW_NUM; r++) run_row(r, v, -1);
    @(negedge clk);
    check_output("done_pulse", ext_load_done_o, 1);
    @(negedge clk);
    check_output("done_one_cycle", ext_load_done_o, 0);
    check_output("idle_busy", busy_o, 0);
    check_output("done_count", done_cnt, d0 + 1);
    check_output("sb_empty", sb_q.size(), 0);
  endtask

  task automatic full_load(input vec_t v);
    int d0;
    d0 = done_cnt;
    apply_stimulus(v);
    finish_load(v, d0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    int d0;
    vecs[0] = make_vec(2,   1,   3,   0, 0, 1'b0, 112,   56,    135);
    vecs[1] = make_vec(0,   0,   3,   1, 1, 1'b1, -16,   0,     71);
    vecs[2] = make_vec(3,   2,   2,   5, 2, 1'b1, 176,   120,   191);
    vecs[3] = make_vec(255, 255, 255, 2, 0, 1'b0, 16304, 16312, 16383);

    #1;
    check_output("rst_req", ext_rd_req_o, 0);
    check_output("rst_valid", ext_load_valid_o, 0);
    check_output("rst_done", ext_load_done_o, 0);
    check_output("rst_busy", busy_o, 0);
    check_output("rst_data", ext_load_data_o, '0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_output("idle_no_req", ext_rd_req_o, 0);

    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d: full window load", i);
      full_load(vecs[i]);
    end

    $display("[TB] abort during row 40");
    d0 = done_cnt;
    apply_stimulus(vecs[0]);
    for (int r = 0; r < 40; r++) run_row(r, vecs[0], -1);
    run_row(40, vecs[0], 3);
    apply_stimulus(vecs[2]);
    check_output("abort_req", ext_rd_req_o, 1);
    check_output("abort_no_done", done_cnt, d0);
    finish_load(vecs[2], d0);

    $display("[TB] reset during data phase");
    d0 = done_cnt;
    apply_stimulus(vecs[1]);
    for (int r = 0; r < 5; r++) run_row(r, vecs[1], -1);
    run_row(5, vecs[1], 2);
    rstn = 1'b0;
    #1;
    check_output("mid_rst_req", ext_rd_req_o, 0);
    check_output("mid_rst_x", ext_rd_x_o, 0);
    check_output("mid_rst_y", ext_rd_y_o, 0);
    check_output("mid_rst_valid", ext_load_valid_o, 0);
    check_output("mid_rst_addr", ext_load_addr_o, 0);
    check_output("mid_rst_data", ext_load_data_o, '0);
    check_output("mid_rst_done", ext_load_done_o, 0);
    check_output("mid_rst_busy", busy_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("post_rst_wait", {ext_rd_req_o, busy_o}, 2'b00);
    end
    check_output("post_rst_no_done", done_cnt, d0);
    full_load(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
